// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load opcodes
// and the stage occupancy states.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 107;
  localparam int MS_TO_WS_BUS_WD = 70;

  localparam logic [2:0] LOAD_OP_LW  = 3'd0;
  localparam logic [2:0] LOAD_OP_LB  = 3'd1;
  localparam logic [2:0] LOAD_OP_LBU = 3'd2;
  localparam logic [2:0] LOAD_OP_LH  = 3'd3;
  localparam logic [2:0] LOAD_OP_LHU = 3'd4;
  localparam logic [2:0] LOAD_OP_LWL = 3'd5;
  localparam logic [2:0] LOAD_OP_LWR = 3'd6;

  // EMPTY: no instruction, WAIT: memory response outstanding,
  // DONE: result ready, waiting for write-back to accept it.
  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_DONE  = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half, extends it, or merges
// the word with rt for the unaligned LWL/LWR pair (little-endian).
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] rt_value_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword of the returned word.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extend or merge according to the load opcode; opcode 7 behaves as LW.
  always_comb begin
    result_o = rdata_i;
    case (load_op_i)
      LOAD_OP_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_LBU: result_o = {24'd0, byte_sel};
      LOAD_OP_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_LHU: result_o = {16'd0, half_sel};
      LOAD_OP_LWL: begin
        case (addr_lo_i)
          2'd0:    result_o = {rdata_i[7:0],  rt_value_i[23:0]};
          2'd1:    result_o = {rdata_i[15:0], rt_value_i[15:0]};
          2'd2:    result_o = {rdata_i[23:0], rt_value_i[7:0]};
          default: result_o = rdata_i;
        endcase
      end
      LOAD_OP_LWR: begin
        case (addr_lo_i)
          2'd0:    result_o = rdata_i;
          2'd1:    result_o = {rt_value_i[31:24], rdata_i[31:8]};
          2'd2:    result_o = {rt_value_i[31:16], rdata_i[31:16]};
          default: result_o = {rt_value_i[31:8],  rdata_i[31:24]};
        endcase
      end
      default:     result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: holds one instruction from execute, waits for
// its data-SRAM response, aligns load data and hands the result to
// write-back. A late response is buffered so the SRAM read data need not
// stay stable while write-back stalls.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [31:0]                ms_to_ds_result,
  output logic [4:0]                 MS_dest,
  output logic                       ms_load_pending
);

  ms_state_e                  state_q, state_d;
  logic                       rbuf_vld_q, rbuf_vld_d;
  logic [31:0]                rbuf_q;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q;

  logic        ms_valid;
  logic        ms_ready_go;
  logic        accept;
  logic        resp_now;
  logic        res_from_mem;
  logic [2:0]  load_op;
  logic        mem_req;
  logic [31:0] rt_value;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] load_word;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign {res_from_mem, load_op, mem_req, rt_value, gr_we, dest, alu_result, pc} = bus_q;

  // Handshake and result selection for the instruction held in the stage.
  always_comb begin
    ms_valid        = (state_q != MS_EMPTY);
    resp_now        = (state_q == MS_WAIT) && data_sram_data_ok;
    ms_ready_go     = (state_q == MS_DONE) || resp_now;
    ms_allowin      = !ms_valid || (ms_ready_go && ws_allowin);
    accept          = es_to_ms_valid && ms_allowin;
    load_word       = rbuf_vld_q ? rbuf_q : data_sram_rdata;
    final_result    = res_from_mem ? load_result : alu_result;
    ms_to_ws_valid  = ms_valid && ms_ready_go;
    ms_to_ws_bus    = {gr_we, dest, final_result, pc};
    ms_to_ds_result = final_result;
    MS_dest         = ms_valid ? dest : 5'd0;
    ms_load_pending = ms_valid && res_from_mem && !ms_ready_go;
  end

  mem_stage_load_align u_load_align (
    .load_op_i  (load_op),
    .addr_lo_i  (alu_result[1:0]),
    .rdata_i    (load_word),
    .rt_value_i (rt_value),
    .result_o   (load_result)
  );

  // Next state: leaving reloads from execute or empties; a response under
  // write-back stall parks the stage in DONE with the data buffered.
  always_comb begin
    state_d    = state_q;
    rbuf_vld_d = rbuf_vld_q;
    if (ms_allowin) begin
      rbuf_vld_d = 1'b0;
      if (accept) begin
        state_d = es_to_ms_bus[102] ? MS_WAIT : MS_DONE;
      end else begin
        state_d = MS_EMPTY;
      end
    end else if (resp_now) begin
      state_d    = MS_DONE;
      rbuf_vld_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= MS_EMPTY;
      rbuf_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rbuf_vld_q <= rbuf_vld_d;
    end
  end

  // Data registers: instruction bus on accept, read data on its response.
  always_ff @(posedge clk) begin
    if (accept) begin
      bus_q <= es_to_ms_bus;
    end
    if (resp_now) begin
      rbuf_q <= data_sram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load alignment variants,
// stalled response buffering, back-to-back issue and reset mid-access.
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [106:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [31:0]  ms_to_ds_result;
  logic [4:0]   MS_dest;
  logic         ms_load_pending;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ds_result   (ms_to_ds_result),
    .MS_dest           (MS_dest),
    .ms_load_pending   (ms_load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [106:0] mk_bus(input logic rfm, input logic [2:0] op,
                                          input logic mreq, input logic [31:0] rt,
                                          input logic we, input logic [4:0] dst,
                                          input logic [31:0] alu, input logic [31:0] pc);
    return {rfm, op, mreq, rt, we, dst, alu, pc};
  endfunction

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a load, respond one cycle after entry with ws ready, check result.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] rdata,
                         input logic [31:0] exp);
    logic [31:0] pc;
    pc = 32'hBFC0_1000 + addr;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1'b1, op, 1'b1, rt, 1'b1, 5'd8, addr, pc);
    cyc();
    es_to_ms_valid = 1'b0;
    #1;
    chk({tag, "_pend"}, 70'(ms_load_pending), 70'd1);
    chk({tag, "_wvld"}, 70'(ms_to_ws_valid), 70'd0);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    chk({tag, "_pend0"}, 70'(ms_load_pending), 70'd0);
    chk({tag, "_bus"}, ms_to_ws_bus, {1'b1, 5'd8, exp, pc});
    cyc();
    data_sram_data_ok = 1'b0;
    #1;
    chk({tag, "_gone"}, 70'(ms_to_ws_valid), 70'd0);
  endtask

  initial begin
    resetn            = 1'b0;
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #2;
    chk("rst_wvld",  70'(ms_to_ws_valid),  70'd0);
    chk("rst_dest",  70'(MS_dest),         70'd0);
    chk("rst_pend",  70'(ms_load_pending), 70'd0);
    chk("rst_allow", 70'(ms_allowin),      70'd1);
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();

    // ALU instruction passes in one cycle.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1'b0, 3'd0, 1'b0, 32'h0, 1'b1, 5'd5, 32'h1234, 32'hBFC0_0000);
    cyc();
    es_to_ms_valid = 1'b0;
    #1;
    chk("alu_wvld", 70'(ms_to_ws_valid), 70'd1);
    chk("alu_bus",  ms_to_ws_bus, {1'b1, 5'd5, 32'h0000_1234, 32'hBFC0_0000});
    chk("alu_dest", 70'(MS_dest), 70'd5);
    chk("alu_ds",   70'(ms_to_ds_result), 70'h1234);
    cyc();
    #1;
    chk("alu_gone", 70'(ms_to_ws_valid), 70'd0);
    chk("alu_dest0", 70'(MS_dest), 70'd0);

    // Load alignment vectors.
    do_load("lb3",  3'd1, 32'h1000_0003, 32'h0,         32'h80AA_BBCC, 32'hFFFF_FF80);
    do_load("lbu3", 3'd2, 32'h1000_0003, 32'h0,         32'h80AA_BBCC, 32'h0000_0080);
    do_load("lh2",  3'd3, 32'h1000_0002, 32'h0,         32'h80AA_BBCC, 32'hFFFF_80AA);
    do_load("lhu0", 3'd4, 32'h1000_0000, 32'h0,         32'h80AA_BBCC, 32'h0000_BBCC);
    do_load("lwl1", 3'd5, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
    do_load("lwr2", 3'd6, 32'h1000_0002, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);
    do_load("lwl3", 3'd5, 32'h1000_0003, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
    do_load("lwr3", 3'd6, 32'h1000_0003, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA);
    do_load("lw",   3'd0, 32'h1000_0000, 32'h0,         32'h1357_9BDF, 32'h1357_9BDF);
    do_load("op7",  3'd7, 32'h1000_0002, 32'h0,         32'h2468_ACE0, 32'h2468_ACE0);

    // Store waits for its response and forwards the address as result.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1'b0, 3'd0, 1'b1, 32'h55, 1'b0, 5'd0, 32'h2000, 32'hBFC0_2000);
    cyc();
    es_to_ms_valid = 1'b0;
    #1;
    chk("st_wait", 70'(ms_to_ws_valid), 70'd0);
    chk("st_pend", 70'(ms_load_pending), 70'd0);
    cyc();
    data_sram_data_ok = 1'b1;
    #1;
    chk("st_bus", ms_to_ws_bus, {1'b0, 5'd0, 32'h2000, 32'hBFC0_2000});
    cyc();
    data_sram_data_ok = 1'b0;

    // Response under write-back stall is buffered.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 32'h0, 1'b1, 5'd7, 32'h3000, 32'hBFC0_3000);
    cyc();
    es_to_ms_valid    = 1'b0;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("buf_allow0", 70'(ms_allowin), 70'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1234_5678;
    #1;
    chk("buf_wvld", 70'(ms_to_ws_valid), 70'd1);
    chk("buf_res1", 70'(ms_to_ds_result), 70'hDEAD_BEEF);
    chk("buf_allow1", 70'(ms_allowin), 70'd0);
    cyc();
    #1;
    chk("buf_allow2", 70'(ms_allowin), 70'd0);
    cyc();
    ws_allowin = 1'b1;
    #1;
    chk("buf_allow3", 70'(ms_allowin), 70'd1);
    chk("buf_bus", ms_to_ws_bus, {1'b1, 5'd7, 32'hDEAD_BEEF, 32'hBFC0_3000});
    cyc();
    #1;
    chk("buf_gone", 70'(ms_to_ws_valid), 70'd0);

    // Back-to-back: LHU then ALU with no bubble.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1'b1, 3'd4, 1'b1, 32'h0, 1'b1, 5'd3, 32'h4002, 32'hBFC0_4000);
    cyc();
    es_to_ms_valid = 1'b0;
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_1234;
    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = mk_bus(1'b0, 3'd0, 1'b0, 32'h0, 1'b1, 5'd9, 32'h55, 32'hBFC0_4004);
    #1;
    chk("b2b_allow", 70'(ms_allowin), 70'd1);
    chk("b2b_lhu", ms_to_ws_bus, {1'b1, 5'd3, 32'h0000_8001, 32'hBFC0_4000});
    cyc();
    data_sram_data_ok = 1'b0;
    es_to_ms_valid    = 1'b0;
    #1;
    chk("b2b_wvld", 70'(ms_to_ws_valid), 70'd1);
    chk("b2b_alu", ms_to_ws_bus, {1'b1, 5'd9, 32'h55, 32'hBFC0_4004});
    cyc();

    // Reset in the middle of an outstanding load.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 32'h0, 1'b1, 5'd4, 32'h5000, 32'hBFC0_5000);
    cyc();
    es_to_ms_valid = 1'b0;
    #1;
    chk("mr_pend", 70'(ms_load_pending), 70'd1);
    resetn = 1'b0;
    #1;
    chk("mr_rst_dest", 70'(MS_dest), 70'd0);
    chk("mr_rst_pend", 70'(ms_load_pending), 70'd0);
    cyc();
    resetn = 1'b1;
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    #1;
    chk("mr_wvld",  70'(ms_to_ws_valid),  70'd0);
    chk("mr_dest",  70'(MS_dest),         70'd0);
    chk("mr_pend0", 70'(ms_load_pending), 70'd0);
    chk("mr_allow", 70'(ms_allowin),      70'd1);
    cyc();
    data_sram_data_ok = 1'b0;
    #1;
    chk("mr_wvld2", 70'(ms_to_ws_valid), 70'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
